jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state is held in a bank of JK cells.
- Computes the per-bit J/K excitation that drives those cells. It is the stage directly upstream of the JK flip-flop: it decides what each JK storage cell sees every clock.
- Provides a ripple terminal-count output for cascading into wider counters and timers.
- Exposes the J/K vectors so the verification bench can check excitation against the JK truth table.

Parameters:
- WIDTH, 4, number of JK state bits.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears the count.
- enable  input  1  count-enable; when 0, all cells receive J=0,K=0 (hold).
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current state (the Q vector of the JK bank).
- count_bar  output  WIDTH  bitwise complement of count.
- tc  output  1  terminal count: high when enable=1 and count is at the terminal value for the current direction.
- j_vec  output  WIDTH  J excitation applied this cycle.
- k_vec  output  WIDTH  K excitation applied this cycle.

Behaviour:
- All state updates occur on the rising edge of clk.
- Priority is reset > load > enable > hold.
- reset=1 at an edge: count becomes 0, count_bar becomes all ones. j_vec/k_vec are don't-care during reset but must be driven (J=0,K=1 per bit).
- load=1, reset=0: per bit, J=v[i] and K=~v[i], where v=load_val. If load_val >= MODULUS, v=MODULUS-1 (clamp). load works regardless of enable and up_dn.
- enable=1, no load, up_dn=1:
  - if count==MODULUS-1, next count = 0 (per bit: J=0, K=count[i], i.e. clear only the set bits);
  - otherwise next count = count+1. Bit i toggles (J=K=1) iff bits 0..i-1 are all 1; else J=K=0.
- enable=1, no load, up_dn=0:
  - if count==0, next count = MODULUS-1 (J=t[i]&~count[i], K=~t[i]&count[i], where t=MODULUS-1);
  - otherwise next count = count-1. Bit i toggles iff bits 0..i-1 are all 0.
- enable=0, no load: J=K=0 on all bits; count is unchanged.
- tc is combinational: enable & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)). It is 0 during load and during reset. It asserts in the same cycle as the wrap and is never registered.
- Direction change: takes effect on the next edge with no lost or extra count. Example: count=5, up_dn goes 1->0 -> next count is 4.
- Latency: count reflects every command one cycle after the edge at which it is sampled.
- Out-of-range state (count >= MODULUS) cannot occur except through clamped load. If it appears anyway, the up direction treats it as non-terminal and increments; the design must not lock up, and the next reset recovers.
- reset mid-count, including while tc=1: count becomes 0 at that edge and tc drops with it. No state outlives reset.
- reset and load together: reset wins. Load and enable together: load wins.

Decomposition:
- Shared package jk_pkg holds:
  - JK command encoding {J,K}: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11;
  - a function that maps a (current bit, next bit) pair to its JK command (excitation table).
- One sub-module, jk_cell_sync: a single JK flip-flop with clk, synchronous active-high reset, J, K, Q and Q_bar. It is instantiated WIDTH times in a generate loop.
- The top level holds the excitation and next-state logic only.

Test Plan:
- reset=1 for 2 cycles, then enable=1, up_dn=1, for 12 cycles -> count 0,1,..,9,0,1. tc=1 only while count=9. j_vec/k_vec at count=7: J=4'b1111, K=4'b1111 (bits 0-3 toggle, 7->8).
- Down from reset, enable=1, up_dn=0 -> count 0,9,8,7. tc=1 at count=0. At the 0->9 step: j_vec=4'b1001, k_vec=4'b0000.
- load=1, load_val=4'd6, enable=0 -> count=6 next cycle. Then load_val=4'd13 -> count=9 (clamp). tc=0 during both load cycles.
- count=4, enable=0 for 5 cycles -> count stays 4, j_vec=k_vec=0, tc=0. Then load=1 with reset=1 -> count=0 (reset wins).
- count=9, up_dn=1, enable=1, reset=1 at the same edge -> count=0, tc drops to 0, and no wrap is reported afterwards.
- MODULUS=16, WIDTH=4 instance, up 17 cycles from 0 -> natural wrap 15->0 with J=0, K=4'b1111. tc=1 exactly once per 16 counts.

Source files
------------

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK command encoding and excitation helpers shared by the counter and its cells.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  // A non-changing bit always maps to HOLD, so wrap excitation only touches bits that move.
  function automatic jk_cmd_t jk_excite(input logic q, input logic q_next);
    case ({q, q_next})
      2'b01:   return JK_SET;
      2'b10:   return JK_CLR;
      default: return JK_HOLD;
    endcase
  endfunction

  function automatic logic jk_next(input logic q, input jk_cmd_t cmd);
    case (cmd)
      JK_HOLD: return q;
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell_sync.sv
// rtl/jk_cell_sync.sv - single JK flip-flop with synchronous active-high reset.
module jk_cell_sync
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= jk_next(q, jk_cmd_t'({j, k}));
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from a bank of JK cells.
// Holds only the excitation/next-state logic; the state lives in jk_cell_sync instances.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic             tc,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  // MODULUS may equal 2**WIDTH, so the clamp compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);

  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic [WIDTH-1:0] up_wrap_j;
  logic [WIDTH-1:0] up_wrap_k;
  logic [WIDTH-1:0] dn_wrap_j;
  logic [WIDTH-1:0] dn_wrap_k;

  assign at_top   = (count == TERM);
  assign at_zero  = (count == '0);
  assign load_eff = ({1'b0, load_val} >= MOD_EXT) ? TERM : load_val;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        assign up_tgl[i] = 1'b1;
        assign dn_tgl[i] = 1'b1;
      end else begin : g_upper
        assign up_tgl[i] = &count[i-1:0];
        assign dn_tgl[i] = ~(|count[i-1:0]);
      end

      assign {up_wrap_j[i], up_wrap_k[i]} = jk_excite(count[i], 1'b0);
      assign {dn_wrap_j[i], dn_wrap_k[i]} = jk_excite(count[i], TERM[i]);

      jk_cell_sync u_cell (
        .clk   (clk),
        .reset (reset),
        .j     (j_vec[i]),
        .k     (k_vec[i]),
        .q     (count[i]),
        .q_bar (count_bar[i])
      );
    end
  endgenerate

  // An out-of-range state is never at_top, so it falls into the ripple-toggle path and moves on.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (reset) begin
      k_vec = '1;
    end else if (load) begin
      j_vec = load_eff;
      k_vec = ~load_eff;
    end else if (enable) begin
      if (up_dn) begin
        if (at_top) begin
          j_vec = up_wrap_j;
          k_vec = up_wrap_k;
        end else begin
          j_vec = up_tgl;
          k_vec = up_tgl;
        end
      end else begin
        if (at_zero) begin
          j_vec = dn_wrap_j;
          k_vec = dn_wrap_k;
        end else begin
          j_vec = dn_tgl;
          k_vec = dn_tgl;
        end
      end
    end
  end

  assign tc = enable & ~reset & ~load & ((up_dn & at_top) | (~up_dn & at_zero));

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - scoreboard bench for jk_mod_counter (MODULUS=10 and MODULUS=16 instances).
module tb_jk_mod_counter;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       ud;
  } step_t;

  logic       clk = 1'b0;
  logic       reset, enable, up_dn, load;
  logic [3:0] load_val, count, count_bar, j_vec, k_vec;
  logic       tc;
  logic       b_reset, b_enable, b_up_dn, b_load;
  logic [3:0] b_load_val, b_count, b_count_bar, b_j_vec, b_k_vec;
  logic       b_tc;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [3:0] sb_q[$];
  logic [3:0] b_sb_q[$];
  logic [3:0] cur_a, cur_b;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .count_bar(count_bar), .tc(tc),
    .j_vec(j_vec), .k_vec(k_vec)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(b_reset), .enable(b_enable), .up_dn(b_up_dn), .load(b_load),
    .load_val(b_load_val), .count(b_count), .count_bar(b_count_bar), .tc(b_tc),
    .j_vec(b_j_vec), .k_vec(b_k_vec)
  );

  function automatic logic [3:0] model_next(input logic [3:0] c, input step_t s, input int m);
    logic [3:0] t;
    t = 4'(m - 1);
    if (s.rst) return 4'd0;
    if (s.ld) return (int'(s.lv) >= m) ? t : s.lv;
    if (!s.en) return c;
    if (s.ud) return (c == t) ? 4'd0 : 4'(c + 4'd1);
    return (c == 4'd0) ? t : 4'(c - 4'd1);
  endfunction

  function automatic logic model_tc(input logic [3:0] c, input step_t s, input int m);
    if (s.rst || s.ld || !s.en) return 1'b0;
    return s.ud ? (c == 4'(m - 1)) : (c == 4'd0);
  endfunction

  // Wraps use set/clear per moving bit, counting steps use toggles, everything else holds.
  function automatic logic [7:0] model_jk(input logic [3:0] c, input step_t s, input int m);
    logic [3:0] n;
    n = model_next(c, s, m);
    if (s.rst) return {4'h0, 4'hF};
    if (s.ld) return {n, ~n};
    if (!s.en) return 8'h00;
    if (s.ud ? (c == 4'(m - 1)) : (c == 4'd0)) return {n & ~c, c & ~n};
    return {c ^ n, c ^ n};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    st.push_back({1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    st.push_back({1'b1, 1'b1, 4'd5, 1'b1, 1'b0});
    for (int i = 0; i < st.size(); i++) begin
      {reset, load, load_val, enable, up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_a, st[i], 10);
      exp_jk = model_jk(cur_a, st[i], 10);
      total_cnt++;
      if ({tc, j_vec, k_vec} !== {exp_tc, exp_jk})
        $display("FAIL reset_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, tc, j_vec, k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      sb_q.push_back(model_next(cur_a, st[i], 10));
      tick();
      exp_n = sb_q.pop_front();
      total_cnt++;
      if ({count, count_bar} !== {exp_n, ~exp_n})
        $display("FAIL reset_cnt[%0d]: count=%0d bar=%b required count=%0d bar=%b", i, count, count_bar, exp_n, ~exp_n);
      else pass_cnt++;
      cur_a = exp_n;
    end
  endtask

  task automatic test_up_wrap;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    for (int i = 0; i < 12; i++) st.push_back({1'b0, 1'b0, 4'd0, 1'b1, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      {reset, load, load_val, enable, up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_a, st[i], 10);
      exp_jk = model_jk(cur_a, st[i], 10);
      total_cnt++;
      if ({tc, j_vec, k_vec} !== {exp_tc, exp_jk})
        $display("FAIL up_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, tc, j_vec, k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      sb_q.push_back(model_next(cur_a, st[i], 10));
      tick();
      exp_n = sb_q.pop_front();
      total_cnt++;
      if ({count, count_bar} !== {exp_n, ~exp_n})
        $display("FAIL up_cnt[%0d]: count=%0d bar=%b required count=%0d", i, count, count_bar, exp_n);
      else pass_cnt++;
      cur_a = exp_n;
    end
  endtask

  task automatic test_down_wrap;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    st.push_back({1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) st.push_back({1'b0, 1'b0, 4'd0, 1'b1, 1'b0});
    for (int i = 0; i < st.size(); i++) begin
      {reset, load, load_val, enable, up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_a, st[i], 10);
      exp_jk = model_jk(cur_a, st[i], 10);
      total_cnt++;
      if ({tc, j_vec, k_vec} !== {exp_tc, exp_jk})
        $display("FAIL down_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, tc, j_vec, k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      sb_q.push_back(model_next(cur_a, st[i], 10));
      tick();
      exp_n = sb_q.pop_front();
      total_cnt++;
      if ({count, count_bar} !== {exp_n, ~exp_n})
        $display("FAIL down_cnt[%0d]: count=%0d bar=%b required count=%0d", i, count, count_bar, exp_n);
      else pass_cnt++;
      cur_a = exp_n;
    end
  endtask

  task automatic test_load_clamp;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    st.push_back({1'b0, 1'b1, 4'd6,  1'b0, 1'b1});
    st.push_back({1'b0, 1'b1, 4'd13, 1'b0, 1'b1});
    st.push_back({1'b0, 1'b1, 4'd10, 1'b1, 1'b1});
    st.push_back({1'b0, 1'b1, 4'd9,  1'b1, 1'b0});
    st.push_back({1'b0, 1'b1, 4'd0,  1'b1, 1'b0});
    st.push_back({1'b0, 1'b1, 4'd4,  1'b1, 1'b1});
    st.push_back({1'b0, 1'b0, 4'd0,  1'b1, 1'b1});
    st.push_back({1'b0, 1'b0, 4'd0,  1'b1, 1'b0});
    st.push_back({1'b0, 1'b0, 4'd0,  1'b1, 1'b0});
    st.push_back({1'b0, 1'b0, 4'd0,  1'b1, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      {reset, load, load_val, enable, up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_a, st[i], 10);
      exp_jk = model_jk(cur_a, st[i], 10);
      total_cnt++;
      if ({tc, j_vec, k_vec} !== {exp_tc, exp_jk})
        $display("FAIL load_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, tc, j_vec, k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      sb_q.push_back(model_next(cur_a, st[i], 10));
      tick();
      exp_n = sb_q.pop_front();
      total_cnt++;
      if ({count, count_bar} !== {exp_n, ~exp_n})
        $display("FAIL load_cnt[%0d]: count=%0d bar=%b required count=%0d", i, count, count_bar, exp_n);
      else pass_cnt++;
      cur_a = exp_n;
    end
  endtask

  task automatic test_hold_reset_load;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    st.push_back({1'b0, 1'b1, 4'd4, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++) st.push_back({1'b0, 1'b0, 4'd0, 1'b0, i[0]});
    st.push_back({1'b1, 1'b1, 4'd7, 1'b1, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      {reset, load, load_val, enable, up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_a, st[i], 10);
      exp_jk = model_jk(cur_a, st[i], 10);
      total_cnt++;
      if ({tc, j_vec, k_vec} !== {exp_tc, exp_jk})
        $display("FAIL hold_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, tc, j_vec, k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      sb_q.push_back(model_next(cur_a, st[i], 10));
      tick();
      exp_n = sb_q.pop_front();
      total_cnt++;
      if ({count, count_bar} !== {exp_n, ~exp_n})
        $display("FAIL hold_cnt[%0d]: count=%0d bar=%b required count=%0d", i, count, count_bar, exp_n);
      else pass_cnt++;
      cur_a = exp_n;
    end
  endtask

  task automatic test_reset_at_terminal;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    st.push_back({1'b0, 1'b1, 4'd9, 1'b0, 1'b1});
    st.push_back({1'b1, 1'b0, 4'd0, 1'b1, 1'b1});
    st.push_back({1'b0, 1'b0, 4'd0, 1'b1, 1'b1});
    st.push_back({1'b0, 1'b0, 4'd0, 1'b1, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      {reset, load, load_val, enable, up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_a, st[i], 10);
      exp_jk = model_jk(cur_a, st[i], 10);
      total_cnt++;
      if ({tc, j_vec, k_vec} !== {exp_tc, exp_jk})
        $display("FAIL rst_tc_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, tc, j_vec, k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      sb_q.push_back(model_next(cur_a, st[i], 10));
      tick();
      exp_n = sb_q.pop_front();
      total_cnt++;
      if ({count, count_bar} !== {exp_n, ~exp_n})
        $display("FAIL rst_tc_cnt[%0d]: count=%0d bar=%b required count=%0d", i, count, count_bar, exp_n);
      else pass_cnt++;
      cur_a = exp_n;
    end
  endtask

  task automatic test_mod16;
    step_t st[$];
    logic [3:0] exp_n;
    logic [7:0] exp_jk;
    logic exp_tc;
    int tc_pulses;
    tc_pulses = 0;
    st.push_back({1'b1, 1'b0, 4'd0, 1'b0, 1'b1});
    for (int i = 0; i < 17; i++) st.push_back({1'b0, 1'b0, 4'd0, 1'b1, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      {b_reset, b_load, b_load_val, b_enable, b_up_dn} = st[i];
      #1;
      exp_tc = model_tc(cur_b, st[i], 16);
      exp_jk = model_jk(cur_b, st[i], 16);
      if (b_tc) tc_pulses++;
      total_cnt++;
      if ({b_tc, b_j_vec, b_k_vec} !== {exp_tc, exp_jk})
        $display("FAIL m16_exc[%0d]: tc/j/k=%b/%b/%b required %b/%b/%b", i, b_tc, b_j_vec, b_k_vec, exp_tc, exp_jk[7:4], exp_jk[3:0]);
      else pass_cnt++;
      b_sb_q.push_back(model_next(cur_b, st[i], 16));
      tick();
      exp_n = b_sb_q.pop_front();
      total_cnt++;
      if ({b_count, b_count_bar} !== {exp_n, ~exp_n})
        $display("FAIL m16_cnt[%0d]: count=%0d bar=%b required count=%0d", i, b_count, b_count_bar, exp_n);
      else pass_cnt++;
      cur_b = exp_n;
    end
    total_cnt++;
    if (tc_pulses !== 1)
      $display("FAIL m16_tc_pulses: got %0d required 1", tc_pulses);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    b_reset = 1'b1; b_enable = 1'b0; b_up_dn = 1'b1; b_load = 1'b0; b_load_val = 4'd0;
    cur_a = 4'd0;
    cur_b = 4'd0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_hold_reset_load();
    test_reset_at_terminal();
    test_mod16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
